signed_block_accumulator: RTL and testbench
===========================================

// Module: signed_block_accumulator
// PURPOSE
//  Widening counterpart of the signed rounding/saturating narrower: integrate-and-dump of signed samples.
//  Sums ACC_LEN narrow signed samples (or fewer, on s_last) into one wider signed result with bit growth.
//  Saturates only if DATA_WIDTH_OUT is narrower than full growth. Valid/ready on both sides.
//  Sits in fixed-point datapaths between a sample source and decimated/averaged consumers.
// PARAMETERS
//  DATA_WIDTH_IN   16  width of signed input sample; must be > 0
//  ACC_LEN          8  samples per block; must be >= 1
//  DATA_WIDTH_OUT  19  width of signed output; must be > 0 and >= DATA_WIDTH_IN; full growth = DATA_WIDTH_IN+$clog2(ACC_LEN)
//  (any violated check -> $error in a generate-if, as for all fixed-point utils)
// PORTS
//  clk      in   1                          clock, all logic on posedge
//  rst      in   1                          synchronous, active-high reset
//  s_valid  in   1                          input sample valid
//  s_ready  out  1                          input ready
//  s_data   in   DATA_WIDTH_IN  (signed)    input sample
//  s_last   in   1                          close current block early with this sample
//  m_valid  out  1                          result valid
//  m_ready  in   1                          consumer ready
//  m_data   out  DATA_WIDTH_OUT (signed)    block sum, saturated to output range
//  m_count  out  $clog2(ACC_LEN+1)          samples in this block (1..ACC_LEN)
//  m_sat    out  1                          1 = m_data was clamped to MAXVAL/MINVAL
// BEHAVIOUR
//  - Reset: cnt=0, acc=0, m_valid=0, m_data=0, m_count=0, m_sat=0; any partial block is discarded.
//  - Input accept: s_valid && s_ready. s_ready = !m_valid || m_ready (combinational; one result buffered).
//  - Internal acc is ACC_W = DATA_WIDTH_IN+$clog2(ACC_LEN) bits (min DATA_WIDTH_IN). s_data is sign-extended.
//    Full-growth sum never wraps.
//  - acc_next = (cnt==0) ? sext(s_data) : acc + sext(s_data). No separate clear cycle.
//  - Completion = accepted sample with cnt==ACC_LEN-1 OR s_last=1. On completion, next edge:
//    m_data=sat(acc_next), m_count=cnt+1, m_sat=clamp flag, m_valid=1, cnt=0.
//    Otherwise: acc=acc_next, cnt=cnt+1.
//  - Latency: m_valid rises 1 cycle after the completing sample is accepted.
//  - Throughput: with m_ready=1, one sample per cycle sustained, including back-to-back blocks.
//  - Saturation: if DATA_WIDTH_OUT >= ACC_W, m_data = sext(acc_next) and m_sat=0. Otherwise clamp:
//    MAXVAL={0,1..1}, MINVAL={1,0..0}; m_sat=1 iff clamped.
//  - Output hold: while m_valid && !m_ready, m_data/m_count/m_sat are stable and s_ready=0.
//  - Simultaneous events: m_ready with a new completion in the same cycle -> old result leaves, new loads,
//    m_valid stays 1. m_ready without completion -> m_valid=0.
//  - Corner cases: s_last on the first sample of a block -> m_count=1. s_last on the ACC_LEN-th sample -> a
//    single normal completion. ACC_LEN=1 -> every sample is a block (registered pass-through with saturation).
//  - s_last is ignored when s_valid=0. No state changes without an accepted sample, except m_valid drain.
//  - rst mid-block or with m_valid=1 drops everything. The next accepted sample starts a new block.
// STRUCTURE
//  - Shared fixed-point package (fixed_point_pkg): function sat_signed(value, out width) returning
//    {clamped, flag}; MAXVAL/MINVAL constant helpers. The rounding narrower reuses these.
//  - One natural sub-module: signed_saturate (combinational, wide->narrow clamp + flag), instantiated
//    only when DATA_WIDTH_OUT < ACC_W.
//  - Top level: counter, accumulator register, output register, handshake logic. No explicit FSM beyond
//    cnt and m_valid.
// TESTING  (DATA_WIDTH_IN=8, ACC_LEN=4, DATA_WIDTH_OUT=10 unless noted; m_ready=1 unless noted)
//  1 samples 1,2,3,4 back-to-back -> m_data=10, m_count=4, m_sat=0; m_valid 1 cycle after sample 4.
//  2 4x(-128) then 4x(127) streamed -> -512 then 508, both m_sat=0, no bubble between blocks.
//  3 DATA_WIDTH_OUT=9: 4x127 -> 255, m_sat=1; 4x(-128) -> -256, m_sat=1; 1,-1,2,-2 -> 0, m_sat=0.
//  4 5, then -7 with s_last=1 -> m_data=-2, m_count=2. Next 1,1,1,1 -> 4, count 4 (no carry-over).
//  5 m_ready=0 after block 1,2,3,4 -> s_ready=0, m_data=10 held 5 cycles. m_ready=1 and a completing
//    sample in the same cycle -> seamless swap.
//  6 rst after samples 9,9 -> outputs zeroed. Then 1,2,3,4 -> 10 (partial sum discarded).
//    ACC_LEN=1: -3 -> -3, m_count=1.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared helpers for the signed fixed-point utilities (block accumulator,
// rounding narrower, ...).
//   acc_width(din, len) : signed width that holds the sum of len samples of
//                         din bits without wrapping
//   max_val(w)/min_val(w): largest / smallest value of a w-bit signed number
//   sat_signed(value, w): clamps a wide signed value into w bits and returns
//                         the clamped value together with a clamp flag
// All helpers work on a 64-bit signed carrier, so the widths they serve must
// stay below 64 bits.
// -----------------------------------------------------------------------------
package fixed_point_pkg;

  localparam int FP_W = 64;

  typedef logic signed [FP_W-1:0] fp_wide_t;

  typedef struct packed {
    logic     flag;   // 1 = value was clamped
    fp_wide_t value;  // clamped value, sign-extended to the carrier width
  } sat_result_t;

  // Full-growth width of a sum of len signed samples of din bits.
  function automatic int acc_width(input int din, input int len);
    return din + $clog2(len);
  endfunction

  function automatic fp_wide_t max_val(input int w);
    return (fp_wide_t'(1) <<< (w - 1)) - fp_wide_t'(1);
  endfunction

  function automatic fp_wide_t min_val(input int w);
    return -(fp_wide_t'(1) <<< (w - 1));
  endfunction

  function automatic sat_result_t sat_signed(input fp_wide_t value, input int w);
    sat_result_t res;
    res.flag  = 1'b0;
    res.value = value;
    if (value > max_val(w)) begin
      res.flag  = 1'b1;
      res.value = max_val(w);
    end else if (value < min_val(w)) begin
      res.flag  = 1'b1;
      res.value = min_val(w);
    end
    return res;
  endfunction

endpackage

// File: rtl/signed_saturate.sv
// -----------------------------------------------------------------------------
// signed_saturate
// Combinational wide-to-narrow signed clamp.
//   in_value  : IN_W-bit signed value
//   out_value : OUT_W-bit signed value, clamped to [MINVAL, MAXVAL]
//   sat_flag  : 1 when in_value did not fit and was clamped
// Only meaningful when OUT_W < IN_W.
// -----------------------------------------------------------------------------
module signed_saturate
  import fixed_point_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_value,
  output logic signed [OUT_W-1:0] out_value,
  output logic                    sat_flag
);

  if (IN_W >= FP_W) begin : g_bad_in_w
    $error("signed_saturate: IN_W must be below the 64-bit helper carrier");
  end
  if (OUT_W <= 0 || OUT_W >= IN_W) begin : g_bad_out_w
    $error("signed_saturate: OUT_W must be > 0 and narrower than IN_W");
  end

  fp_wide_t                wide_value;
  sat_result_t             result;
  // Bits above OUT_W are sign copies after clamping and carry no information.
  logic [FP_W-OUT_W-1:0]   upper_unused;

  assign wide_value   = {{(FP_W-IN_W){in_value[IN_W-1]}}, in_value};
  assign result       = sat_signed(wide_value, OUT_W);
  assign out_value    = result.value[OUT_W-1:0];
  assign upper_unused = result.value[FP_W-1:OUT_W];
  assign sat_flag     = result.flag;

endmodule

// File: rtl/signed_block_accumulator.sv
// -----------------------------------------------------------------------------
// signed_block_accumulator
// Integrate-and-dump of signed samples: sums ACC_LEN samples (fewer when
// s_last closes the block early) into one wider signed result, saturated to
// DATA_WIDTH_OUT bits when that is narrower than the full-growth width.
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_ready : input handshake; s_data signed sample, s_last closes block
//   m_valid/m_ready : output handshake
//   m_data          : block sum (saturated), m_count samples in the block,
//                     m_sat 1 when m_data was clamped
// One result is buffered; s_ready drops only while that result is stalled.
// -----------------------------------------------------------------------------
module signed_block_accumulator
  import fixed_point_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int ACC_LEN        = 8,
  parameter int DATA_WIDTH_OUT = 19
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [DATA_WIDTH_IN-1:0]   s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic signed [DATA_WIDTH_OUT-1:0]  m_data,
  output logic [$clog2(ACC_LEN+1)-1:0]      m_count,
  output logic                              m_sat
);

  localparam int ACC_W = acc_width(DATA_WIDTH_IN, ACC_LEN);
  localparam int CNT_W = $clog2(ACC_LEN + 1);

  if (DATA_WIDTH_IN <= 0) begin : g_bad_din
    $error("signed_block_accumulator: DATA_WIDTH_IN must be > 0");
  end
  if (ACC_LEN < 1) begin : g_bad_len
    $error("signed_block_accumulator: ACC_LEN must be >= 1");
  end
  if (DATA_WIDTH_OUT <= 0 || DATA_WIDTH_OUT < DATA_WIDTH_IN) begin : g_bad_dout
    $error("signed_block_accumulator: DATA_WIDTH_OUT must be > 0 and >= DATA_WIDTH_IN");
  end
  if (ACC_W >= FP_W || DATA_WIDTH_OUT >= FP_W) begin : g_bad_carrier
    $error("signed_block_accumulator: widths must stay below 64 bits");
  end

  logic [CNT_W-1:0]                cnt_reg;
  logic signed [ACC_W-1:0]         acc_reg;
  logic                            m_valid_reg;
  logic signed [DATA_WIDTH_OUT-1:0] m_data_reg;
  logic [CNT_W-1:0]                m_count_reg;
  logic                            m_sat_reg;

  logic                            accept;
  logic                            last_slot;
  logic                            complete;
  logic [CNT_W-1:0]                count_next;
  logic signed [ACC_W-1:0]         sample_ext;
  logic signed [ACC_W-1:0]         acc_next;
  logic signed [DATA_WIDTH_OUT-1:0] out_value;
  logic                            out_sat;

  // A waiting result may leave in the same cycle a new one is loaded.
  assign s_ready    = !m_valid_reg || m_ready;
  assign accept     = s_valid && s_ready;
  assign last_slot  = (cnt_reg == CNT_W'(ACC_LEN - 1));
  assign complete   = accept && (s_last || last_slot);
  assign count_next = cnt_reg + CNT_W'(1);

  if (ACC_W == DATA_WIDTH_IN) begin : g_ext_none
    assign sample_ext = s_data;
  end else begin : g_ext_sign
    assign sample_ext = {{(ACC_W-DATA_WIDTH_IN){s_data[DATA_WIDTH_IN-1]}}, s_data};
  end

  // First sample of a block overwrites the accumulator, so no clear cycle is
  // needed between blocks. ACC_W is full growth, so the sum never wraps.
  assign acc_next = (cnt_reg == '0) ? sample_ext : acc_reg + sample_ext;

  if (DATA_WIDTH_OUT < ACC_W) begin : g_sat
    signed_saturate #(
      .IN_W  (ACC_W),
      .OUT_W (DATA_WIDTH_OUT)
    ) u_sat (
      .in_value  (acc_next),
      .out_value (out_value),
      .sat_flag  (out_sat)
    );
  end else if (DATA_WIDTH_OUT == ACC_W) begin : g_same
    assign out_value = acc_next;
    assign out_sat   = 1'b0;
  end else begin : g_widen
    assign out_value = {{(DATA_WIDTH_OUT-ACC_W){acc_next[ACC_W-1]}}, acc_next};
    assign out_sat   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_count_reg <= '0;
      m_sat_reg   <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= count_next;
          acc_reg <= acc_next;
        end
      end
      // Completion implies acceptance, which implies the buffer is free or
      // draining, so the held result is never overwritten while stalled.
      if (complete) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= out_value;
        m_count_reg <= count_next;
        m_sat_reg   <= out_sat;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_count = m_count_reg;
  assign m_sat   = m_sat_reg;

endmodule

// File: tb/tb_signed_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_signed_block_accumulator
// Three instances share one stimulus stream:
//   dut_a : DATA_WIDTH_IN=8, ACC_LEN=4, DATA_WIDTH_OUT=10 (full growth)
//   dut_b : DATA_WIDTH_IN=8, ACC_LEN=4, DATA_WIDTH_OUT=9  (saturating)
//   dut_c : DATA_WIDTH_IN=8, ACC_LEN=1, DATA_WIDTH_OUT=10 (pass-through)
// Expected block results come from summing the sample list and clamping it
// arithmetically to the output range.
// -----------------------------------------------------------------------------
module tb_signed_block_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              s_valid;
  logic signed [7:0] s_data;
  logic              s_last;
  logic              m_ready;

  logic              a_s_ready, a_m_valid, a_m_sat;
  logic signed [9:0] a_m_data;
  logic [2:0]        a_m_count;
  logic              b_s_ready, b_m_valid, b_m_sat;
  logic signed [8:0] b_m_data;
  logic [2:0]        b_m_count;
  logic              c_s_ready, c_m_valid, c_m_sat;
  logic signed [9:0] c_m_data;
  logic [0:0]        c_m_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  signed_block_accumulator #(.DATA_WIDTH_IN(8), .ACC_LEN(4), .DATA_WIDTH_OUT(10)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .m_count(a_m_count), .m_sat(a_m_sat));

  signed_block_accumulator #(.DATA_WIDTH_IN(8), .ACC_LEN(4), .DATA_WIDTH_OUT(9)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .m_count(b_m_count), .m_sat(b_m_sat));

  signed_block_accumulator #(.DATA_WIDTH_IN(8), .ACC_LEN(1), .DATA_WIDTH_OUT(10)) dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(c_s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(c_m_valid), .m_ready(m_ready), .m_data(c_m_data),
    .m_count(c_m_count), .m_sat(c_m_sat));

  // Reference: clamp an exact integer sum into a w-bit signed range.
  function automatic int ref_clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic bit ref_clamped(input int v, input int w);
    return ref_clamp(v, w) != v;
  endfunction

  // Present one sample for one clock; outputs are observed 1 ns after the edge.
  task automatic send(input int d, input bit last);
    s_valid = 1'b1;
    s_data  = 8'(d);
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input bit last);
    s_valid = 1'b0;
    s_last  = last;
    @(posedge clk);
    #1;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", a_m_valid); else pass_cnt++;
    total_cnt++; if (a_m_data !== 10'sd0) $display("FAIL reset_data: got %0d want 0", a_m_data); else pass_cnt++;
    total_cnt++; if (a_m_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", a_m_count); else pass_cnt++;
    total_cnt++; if (a_m_sat !== 1'b0) $display("FAIL reset_sat: got %0b want 0", a_m_sat); else pass_cnt++;
    total_cnt++; if (b_m_valid !== 1'b0 || c_m_valid !== 1'b0) $display("FAIL reset_valid_bc: got %0b/%0b want 0/0", b_m_valid, c_m_valid); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (a_s_ready !== 1'b1) $display("FAIL reset_s_ready: got %0b want 1", a_s_ready); else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_basic();
    int d[4] = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      send(d[i], 1'b0);
      if (i < 3) begin
        total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %0b want 0", i, a_m_valid); else pass_cnt++;
      end
    end
    total_cnt++; if (a_m_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", a_m_valid); else pass_cnt++;
    total_cnt++; if (int'(a_m_data) !== 10) $display("FAIL basic_data: got %0d want 10", a_m_data); else pass_cnt++;
    total_cnt++; if (int'(a_m_count) !== 4) $display("FAIL basic_count: got %0d want 4", a_m_count); else pass_cnt++;
    total_cnt++; if (a_m_sat !== 1'b0) $display("FAIL basic_sat: got %0b want 0", a_m_sat); else pass_cnt++;
    $display("basic: 1,2,3,4 -> data=%0d count=%0d sat=%0b", a_m_data, a_m_count, a_m_sat);
    idle(1'b0);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL basic_drain: got %0b want 0", a_m_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sum;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = (i < 4) ? -128 : 127;
      total_cnt++; if (a_s_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %0b want 1", i, a_s_ready); else pass_cnt++;
      send(v, 1'b0);
      sum += v;
      if (i == 3 || i == 7) begin
        total_cnt++; if (a_m_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %0b want 1", i, a_m_valid); else pass_cnt++;
        total_cnt++; if (int'(a_m_data) !== sum || a_m_sat !== 1'b0) $display("FAIL b2b_data_a[%0d]: got %0d/%0b want %0d/0", i, a_m_data, a_m_sat, sum); else pass_cnt++;
        total_cnt++; if (int'(b_m_data) !== ref_clamp(sum, 9) || b_m_sat !== ref_clamped(sum, 9)) $display("FAIL b2b_data_b[%0d]: got %0d/%0b want %0d/%0b", i, b_m_data, b_m_sat, ref_clamp(sum, 9), ref_clamped(sum, 9)); else pass_cnt++;
        $display("b2b: block sum=%0d a=%0d b=%0d sat_b=%0b", sum, a_m_data, b_m_data, b_m_sat);
        sum = 0;
      end else begin
        total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL b2b_mid_valid[%0d]: got %0b want 0", i, a_m_valid); else pass_cnt++;
      end
    end
    idle(1'b0);
  endtask

  task automatic test_saturation();
    int blk[3][4] = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128}, '{1, -1, 2, -2}};
    int exp_b[3]  = '{255, -256, 0};
    bit exp_bs[3] = '{1'b1, 1'b1, 1'b0};
    int exp_a[3]  = '{508, -512, 0};
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) send(blk[i][k], 1'b0);
      total_cnt++; if (int'(b_m_data) !== exp_b[i] || b_m_sat !== exp_bs[i]) $display("FAIL sat_b[%0d]: got %0d/%0b want %0d/%0b", i, b_m_data, b_m_sat, exp_b[i], exp_bs[i]); else pass_cnt++;
      total_cnt++; if (int'(a_m_data) !== exp_a[i] || a_m_sat !== 1'b0) $display("FAIL sat_a[%0d]: got %0d/%0b want %0d/0", i, a_m_data, a_m_sat, exp_a[i]); else pass_cnt++;
      $display("saturation: block %0d b=%0d sat=%0b a=%0d", i, b_m_data, b_m_sat, a_m_data);
    end
    idle(1'b0);
  endtask

  task automatic test_early_last();
    send(5, 1'b0);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL last_first_valid: got %0b want 0", a_m_valid); else pass_cnt++;
    send(-7, 1'b1);
    total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== -2 || int'(a_m_count) !== 2) $display("FAIL last_early: got v=%0b d=%0d c=%0d want v=1 d=-2 c=2", a_m_valid, a_m_data, a_m_count); else pass_cnt++;
    $display("early_last: 5,-7(last) -> data=%0d count=%0d", a_m_data, a_m_count);
    for (int k = 0; k < 4; k++) begin
      send(1, 1'b0);
      if (k == 0) begin
        total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL last_carry_valid: got %0b want 0", a_m_valid); else pass_cnt++;
      end
    end
    total_cnt++; if (int'(a_m_data) !== 4 || int'(a_m_count) !== 4) $display("FAIL last_next_block: got d=%0d c=%0d want d=4 c=4", a_m_data, a_m_count); else pass_cnt++;
    send(6, 1'b1);
    total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== 6 || int'(a_m_count) !== 1) $display("FAIL last_single: got v=%0b d=%0d c=%0d want v=1 d=6 c=1", a_m_valid, a_m_data, a_m_count); else pass_cnt++;
    // s_last without s_valid must not close the block.
    send(2, 1'b0);
    idle(1'b1);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL last_ignored: got %0b want 0", a_m_valid); else pass_cnt++;
    send(3, 1'b0);
    send(4, 1'b0);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL last_third_valid: got %0b want 0", a_m_valid); else pass_cnt++;
    send(5, 1'b1);
    total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== 14 || int'(a_m_count) !== 4) $display("FAIL last_on_full: got v=%0b d=%0d c=%0d want v=1 d=14 c=4", a_m_valid, a_m_data, a_m_count); else pass_cnt++;
    idle(1'b0);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL last_on_full_single: got %0b want 0", a_m_valid); else pass_cnt++;
    send(8, 1'b1);
    total_cnt++; if (int'(a_m_data) !== 8 || int'(a_m_count) !== 1) $display("FAIL last_after_full: got d=%0d c=%0d want d=8 c=1", a_m_data, a_m_count); else pass_cnt++;
    idle(1'b0);
  endtask

  task automatic test_random_blocks();
    for (int blk = 0; blk < 12; blk++) begin
      int n;
      int sum;
      bit last_final;
      n = int'($urandom_range(1, 4));
      last_final = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      sum = 0;
      for (int k = 0; k < n; k++) begin
        int v;
        if ($urandom_range(0, 2) == 0) begin
          idle(1'($urandom_range(0, 1)));
          total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL rand_gap_valid[%0d]: got %0b want 0", blk, a_m_valid); else pass_cnt++;
        end
        v = int'($urandom_range(0, 255)) - 128;
        sum += v;
        send(v, (k == n - 1) ? last_final : 1'b0);
        if (k < n - 1) begin
          total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL rand_mid_valid[%0d]: got %0b want 0", blk, a_m_valid); else pass_cnt++;
        end
      end
      total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== ref_clamp(sum, 10) || int'(a_m_count) !== n || a_m_sat !== 1'b0) $display("FAIL rand_a[%0d]: got v=%0b d=%0d c=%0d s=%0b want v=1 d=%0d c=%0d s=0", blk, a_m_valid, a_m_data, a_m_count, a_m_sat, ref_clamp(sum, 10), n); else pass_cnt++;
      total_cnt++; if (int'(b_m_data) !== ref_clamp(sum, 9) || b_m_sat !== ref_clamped(sum, 9) || int'(b_m_count) !== n) $display("FAIL rand_b[%0d]: got d=%0d s=%0b c=%0d want d=%0d s=%0b c=%0d", blk, b_m_data, b_m_sat, b_m_count, ref_clamp(sum, 9), ref_clamped(sum, 9), n); else pass_cnt++;
      $display("random: block %0d n=%0d sum=%0d a=%0d b=%0d sat_b=%0b", blk, n, sum, a_m_data, b_m_data, b_m_sat);
    end
    idle(1'b0);
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== 10) $display("FAIL bp_loaded: got v=%0b d=%0d want v=1 d=10", a_m_valid, a_m_data); else pass_cnt++;
    total_cnt++; if (a_s_ready !== 1'b0) $display("FAIL bp_s_ready: got %0b want 0", a_s_ready); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'sd50;
      s_last  = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== 10 || int'(a_m_count) !== 4 || a_m_sat !== 1'b0 || a_s_ready !== 1'b0) $display("FAIL bp_hold[%0d]: got v=%0b d=%0d c=%0d s=%0b rdy=%0b want v=1 d=10 c=4 s=0 rdy=0", i, a_m_valid, a_m_data, a_m_count, a_m_sat, a_s_ready); else pass_cnt++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    total_cnt++; if (a_s_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", a_s_ready); else pass_cnt++;
    send(7, 1'b1);
    total_cnt++; if (a_m_valid !== 1'b1 || int'(a_m_data) !== 7 || int'(a_m_count) !== 1) $display("FAIL bp_swap: got v=%0b d=%0d c=%0d want v=1 d=7 c=1", a_m_valid, a_m_data, a_m_count); else pass_cnt++;
    $display("backpressure: held 10 for 5 cycles, swapped to data=%0d count=%0d", a_m_data, a_m_count);
    idle(1'b0);
    total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL bp_drain: got %0b want 0", a_m_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send(9, 1'b0);
    send(9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total_cnt++; if (a_m_valid !== 1'b0 || a_m_data !== 10'sd0 || a_m_count !== 3'd0) $display("FAIL rst_mid_zero: got v=%0b d=%0d c=%0d want 0/0/0", a_m_valid, a_m_data, a_m_count); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      send(i, 1'b0);
      if (i == 2) begin
        total_cnt++; if (a_m_valid !== 1'b0) $display("FAIL rst_mid_partial: got %0b want 0", a_m_valid); else pass_cnt++;
      end
    end
    total_cnt++; if (int'(a_m_data) !== 10 || int'(a_m_count) !== 4) $display("FAIL rst_mid_block: got d=%0d c=%0d want d=10 c=4", a_m_data, a_m_count); else pass_cnt++;
    $display("reset_mid: partial 9,9 dropped, next block data=%0d", a_m_data);
    idle(1'b0);
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total_cnt++; if (a_m_valid !== 1'b0 || a_m_data !== 10'sd0 || a_m_sat !== 1'b0 || a_m_count !== 3'd0) $display("FAIL rst_stalled: got v=%0b d=%0d s=%0b c=%0d want 0/0/0/0", a_m_valid, a_m_data, a_m_sat, a_m_count); else pass_cnt++;
    m_ready = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_acc_len1();
    for (int i = 0; i < 8; i++) begin
      int v;
      v = (i == 0) ? -3 : int'($urandom_range(0, 255)) - 128;
      send(v, 1'b0);
      total_cnt++; if (c_m_valid !== 1'b1 || int'(c_m_data) !== v || int'(c_m_count) !== 1 || c_m_sat !== 1'b0) $display("FAIL len1[%0d]: got v=%0b d=%0d c=%0d s=%0b want v=1 d=%0d c=1 s=0", i, c_m_valid, c_m_data, c_m_count, c_m_sat, v); else pass_cnt++;
      $display("acc_len1: sample %0d -> data=%0d count=%0d", v, c_m_data, c_m_count);
    end
    idle(1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_early_last();
    test_random_blocks();
    test_backpressure();
    test_reset_mid();
    test_acc_len1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
